// File: rtl/snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// snoop_bus_arbiter
//   Round-robin arbiter and sequencer for the shared snoop bus. It grants one
//   snoop controller per transaction, pulses tx_begin_o in the first grant
//   cycle, holds the grant until the bus reports the last response, and then
//   inserts one idle (GAP) cycle before it arbitrates again.
//
//   Optional feature (macro SNOOP_ARB_WATCHDOG_EN): a BUSY watchdog. After
//   timeout_p BUSY cycles without tx_done_i it releases the grant and sets the
//   sticky error_o. Without the macro no counter is built, error_o is tied 0
//   and BUSY waits indefinitely.
//
// Ports:
//   clk_i       core clock
//   reset_i     synchronous reset, active-high
//   req_i       per-cache request (level, held until granted)
//   grant_o     one-hot grant, zero when the bus has no owner
//   grant_id_o  binary index of the owner, 0 when none
//   tx_begin_o  one-cycle pulse in the first cycle of a grant
//   tx_done_i   last response seen on the bus; ends the transaction
//   busy_o      high in GRANT, BUSY and GAP
//   error_o     sticky watchdog error
// ---------------------------------------------------------------------------
module snoop_bus_arbiter #(
    parameter int num_caches_p = 2,
    parameter int timeout_p    = 1024,
    localparam int id_width_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_caches_p-1:0] req_i,
    output logic [num_caches_p-1:0] grant_o,
    output logic [id_width_lp-1:0]  grant_id_o,
    output logic                    tx_begin_o,
    input  logic                    tx_done_i,
    output logic                    busy_o,
    output logic                    error_o
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;

    state_t                  state;
    logic [num_caches_p-1:0] grant;
    logic [id_width_lp-1:0]  grant_id;   // doubles as the latched owner
    logic                    tx_begin;
    logic                    busy;
    logic [id_width_lp-1:0]  ptr;        // highest-priority requester

    logic                    found;
    logic [id_width_lp-1:0]  winner;
    logic [id_width_lp-1:0]  ptr_next;
    int                      idx;

    // Rotating priority scan: first set request at or above ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < num_caches_p; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_caches_p) idx = idx - num_caches_p;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = id_width_lp'(idx);
            end
        end
    end

    // Explicit wrap so non-power-of-two cache counts rotate correctly.
    assign ptr_next = (winner == id_width_lp'(num_caches_p - 1)) ? '0
                                                                 : winner + id_width_lp'(1);

`ifdef SNOOP_ARB_WATCHDOG_EN
    localparam int cnt_w_lp = $clog2(timeout_p + 1);
    logic [cnt_w_lp-1:0] wd_cnt;
    logic                error;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            tx_begin <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
`ifdef SNOOP_ARB_WATCHDOG_EN
            wd_cnt   <= '0;
            error    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state         <= GRANT;
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        grant_id      <= winner;
                        tx_begin      <= 1'b1;
                        busy          <= 1'b1;
                        ptr           <= ptr_next;
`ifdef SNOOP_ARB_WATCHDOG_EN
                        wd_cnt        <= '0;
`endif
                    end
                end
                GRANT: begin
                    tx_begin <= 1'b0;
                    if (tx_done_i) begin
                        // Single-cycle transaction: release straight away.
                        state    <= GAP;
                        grant    <= '0;
                        grant_id <= '0;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_done_i) begin
                        state    <= GAP;
                        grant    <= '0;
                        grant_id <= '0;
                    end
`ifdef SNOOP_ARB_WATCHDOG_EN
                    // wd_cnt holds completed BUSY cycles; this is the
                    // timeout_p-th one, so force the bus free.
                    else if (wd_cnt == cnt_w_lp'(timeout_p - 1)) begin
                        state    <= GAP;
                        grant    <= '0;
                        grant_id <= '0;
                        error    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + cnt_w_lp'(1);
                    end
`endif
                end
                GAP: begin
                    // Requests are ignored here; arbitration resumes in IDLE.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o    = grant;
    assign grant_id_o = grant_id;
    assign tx_begin_o = tx_begin;
    assign busy_o     = busy;
`ifdef SNOOP_ARB_WATCHDOG_EN
    assign error_o    = error;
`else
    assign error_o    = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_snoop_bus_arbiter
//   Self-checking bench. A two-cache instance is driven from a vector table
//   (reset state, single transaction, alternating back-to-back grants,
//   one-cycle grant, reset mid-transaction). A four-cache instance covers the
//   pointer wrap by hand and then runs randomized traffic against a
//   transaction-level reference model. The watchdog sequence is built only
//   when SNOOP_ARB_WATCHDOG_EN is defined.
// ---------------------------------------------------------------------------
module tb_snoop_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // two-cache instance
    logic       rst2 = 1'b1;
    logic [1:0] req2 = '0;
    logic       done2 = 1'b0;
    logic [1:0] g2;
    logic       id2;
    logic       beg2, busy2, err2;

    // four-cache instance
    logic       rst4 = 1'b1;
    logic [3:0] req4 = '0;
    logic       done4 = 1'b0;
    logic [3:0] g4;
    logic [1:0] id4;
    logic       beg4, busy4, err4;

`ifdef SNOOP_ARB_WATCHDOG_EN
    localparam int TO2 = 16;
`else
    localparam int TO2 = 1024;
`endif

    snoop_bus_arbiter #(.num_caches_p(2), .timeout_p(TO2)) dut2 (
        .clk_i(clk), .reset_i(rst2), .req_i(req2), .grant_o(g2),
        .grant_id_o(id2), .tx_begin_o(beg2), .tx_done_i(done2),
        .busy_o(busy2), .error_o(err2));

    snoop_bus_arbiter #(.num_caches_p(4), .timeout_p(1024)) dut4 (
        .clk_i(clk), .reset_i(rst4), .req_i(req4), .grant_o(g4),
        .grant_id_o(id4), .tx_begin_o(beg4), .tx_done_i(done4),
        .busy_o(busy4), .error_o(err4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one row = inputs held over one rising edge, outputs expected after it
    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       done;
        logic [1:0] g;
        logic       id;
        logic       beg;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [1:0] req, input logic done,
                       input logic [1:0] g, input logic id, input logic beg, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done;
        v.g = g; v.id = id; v.beg = beg; v.busy = busy;
        vq.push_back(v);
    endtask

    // four-cache transaction: grant in the GRANT cycle, done right away
    task automatic tx4(input logic [3:0] r, input int exp_id);
        logic [3:0] oh;
        oh = 4'b0001 << exp_id;
        req4 = r; done4 = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("wrap grant req=%b", r), 32'(g4), 32'(oh));
        chk($sformatf("wrap id req=%b", r), 32'(id4), 32'(exp_id));
        chk("wrap tx_begin", 32'(beg4), 32'd1);
        req4 = '0; done4 = 1'b1;
        @(posedge clk); #1;
        chk("wrap gap grant", 32'(g4), 32'd0);
        chk("wrap gap busy", 32'(busy4), 32'd1);
        done4 = 1'b0;
        @(posedge clk); #1;
        chk("wrap idle busy", 32'(busy4), 32'd0);
    endtask

    // reference model state for the random run
    int ph;        // 0 idle, 1 first grant cycle, 2 holding, 3 gap
    int own;
    int prio;
    int wd;
    bit merr;

    task automatic model_step(input bit rst, input logic [3:0] req, input bit done);
        if (rst) begin
            ph = 0; own = 0; prio = 0; wd = 0; merr = 0;
        end else begin
            case (ph)
                0: if (req != 0) begin
                       for (int k = 0; k < 4; k++) begin
                           int c;
                           c = (prio + k) % 4;
                           if (req[c]) begin own = c; break; end
                       end
                       prio = (own + 1) % 4;
                       wd = 0;
                       ph = 1;
                   end
                1: ph = done ? 3 : 2;
                2: begin
                       if (done) ph = 3;
`ifdef SNOOP_ARB_WATCHDOG_EN
                       else begin
                           wd++;
                           if (wd == 1024) begin ph = 3; merr = 1; end
                       end
`endif
                   end
                default: ph = 0;
            endcase
        end
    endtask

    initial begin
        // ---------------- table-driven sequence on the two-cache DUT
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);   // reset state
        add(0, 2'b01, 0, 2'b01, 0, 1, 1);   // grant cache 0, cycle 1
        add(0, 2'b00, 0, 2'b01, 0, 0, 1);   // owner drops req, grant held
        add(0, 2'b00, 0, 2'b01, 0, 0, 1);
        add(0, 2'b00, 0, 2'b01, 0, 0, 1);
        add(0, 2'b00, 0, 2'b01, 0, 0, 1);
        add(0, 2'b00, 1, 2'b00, 0, 0, 1);   // done cycle 5 -> grant 0 cycle 6
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);   // busy low cycle 7
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);   // reset pointer
        for (int t = 0; t < 4; t++) begin   // alternating 0,1,0,1 grants
            logic [1:0] oh;
            logic       who;
            who = t[0];
            oh  = who ? 2'b10 : 2'b01;
            add(0, 2'b11, 0, oh,    who, 1, 1);
            add(0, 2'b11, 0, oh,    who, 0, 1);
            add(0, 2'b11, 0, oh,    who, 0, 1);
            add(0, 2'b11, 1, 2'b00, 0,   0, 1);   // gap, req ignored
            add(0, 2'b11, 0, 2'b00, 0,   0, 0);   // idle
        end
        add(0, 2'b01, 0, 2'b01, 0, 1, 1);   // ptr back at 0
        add(0, 2'b00, 1, 2'b00, 0, 0, 1);   // done in GRANT cycle -> gap
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b10, 0, 2'b10, 1, 1, 1);   // owner 1
        add(0, 2'b00, 0, 2'b10, 1, 0, 1);   // busy
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);   // reset mid-transaction
        add(0, 2'b11, 0, 2'b01, 0, 1, 1);   // ptr was cleared -> cache 0
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b00, 1, 2'b00, 0, 0, 0);   // done ignored in idle

        for (int i = 0; i < vq.size(); i++) begin
            rst2 = vq[i].rst; req2 = vq[i].req; done2 = vq[i].done;
            @(posedge clk); #1;
            chk($sformatf("vec%0d grant", i),    32'(g2),    32'(vq[i].g));
            chk($sformatf("vec%0d id", i),       32'(id2),   32'(vq[i].id));
            chk($sformatf("vec%0d tx_begin", i), 32'(beg2),  32'(vq[i].beg));
            chk($sformatf("vec%0d busy", i),     32'(busy2), 32'(vq[i].busy));
            chk($sformatf("vec%0d error", i),    32'(err2),  32'd0);
        end

`ifdef SNOOP_ARB_WATCHDOG_EN
        // ---------------- watchdog on the two-cache DUT (timeout 16)
        rst2 = 1'b1; @(posedge clk); #1; rst2 = 1'b0;
        req2 = 2'b01; done2 = 1'b0;
        @(posedge clk); #1;
        chk("wd grant", 32'(g2), 32'd1);
        req2 = 2'b00;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            chk($sformatf("wd hold %0d", c), 32'(g2), 32'd1);
            chk($sformatf("wd no err %0d", c), 32'(err2), 32'd0);
        end
        @(posedge clk); #1;
        chk("wd released", 32'(g2), 32'd0);
        chk("wd error set", 32'(err2), 32'd1);
        @(posedge clk); #1;
        req2 = 2'b11;
        @(posedge clk); #1;
        chk("wd next grant", 32'(g2), 32'b10);
        chk("wd error sticky", 32'(err2), 32'd1);
        rst2 = 1'b1; req2 = 2'b00;
        @(posedge clk); #1;
        chk("wd error cleared", 32'(err2), 32'd0);
`endif
        rst2 = 1'b0; req2 = '0; done2 = 1'b0;

        // ---------------- pointer wrap on the four-cache DUT
        rst4 = 1'b1; @(posedge clk); #1; rst4 = 1'b0;
        tx4(4'b0100, 2);   // ptr -> 3
        tx4(4'b0101, 0);   // wrap to cache 0, ptr -> 1
        tx4(4'b0101, 2);
        tx4(4'b1000, 3);   // ptr wraps to 0
        tx4(4'b1111, 0);

        // ---------------- randomized traffic against the reference model
        rst4 = 1'b1; req4 = '0; done4 = 1'b0;
        model_step(1, '0, 0);
        @(posedge clk); #1;
        rst4 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] eg;
            int         eid;
            rst4  = ($urandom_range(0, 99) == 0);
            req4  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            done4 = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step(rst4, req4, done4);
            #1;
            eg  = (ph == 1 || ph == 2) ? (4'b0001 << own) : 4'b0000;
            eid = (ph == 1 || ph == 2) ? own : 0;
            if (g4 !== eg || id4 !== 2'(eid) || beg4 !== (ph == 1) ||
                busy4 !== (ph != 0) || err4 !== merr) begin
                failures++;
                $display("FAIL rand cyc%0d: got g=%b id=%0d beg=%b busy=%b err=%b expected g=%b id=%0d beg=%0d busy=%0d err=%0d",
                         n, g4, id4, beg4, busy4, err4, eg, eid, (ph == 1), (ph != 0), merr);
            end
            checks++;
            chk($sformatf("rand onehot0 cyc%0d", n), 32'($onehot0(g4)), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared snoop bus in memsys_top.
- Accepts bus requests from num_caches_p snoop controllers and grants exactly one owner per transaction.
- Pulses the transaction-begin strobe, then holds the grant until the bus reports the last response.
- Inserts one idle cycle between transactions so every snoop controller can return to idle before the next broadcast.

Parameters:
num_caches_p, 2, number of requesting snoop controllers (1..8)
timeout_p, 1024, max cycles in BUSY before the watchdog trips (used only with the optional feature)
id_width_lp, derived, max(1, $clog2(num_caches_p))

Ports:
clk_i  in  1  core clock
reset_i  in  1  synchronous reset, active-high
req_i  in  num_caches_p  per-cache bus request; level, held until granted
grant_o  out  num_caches_p  one-hot grant; all zero when no owner
grant_id_o  out  id_width_lp  binary index of the current owner; 0 when none
tx_begin_o  out  1  single-cycle pulse in the first cycle of a grant
tx_done_i  in  1  last response received on the bus (sb_last_rx); ends the transaction
busy_o  out  1  high in GRANT, BUSY and GAP
error_o  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- Reset: synchronous, active-high.
  - State = IDLE; grant_o = 0; grant_id_o = 0; tx_begin_o = 0; busy_o = 0; error_o = 0.
  - Priority pointer ptr_r = 0, i.e. cache 0 has highest priority first.
- States:
  - IDLE -> GRANT when |req_i.
    - Winner = first set bit of req_i scanning from ptr_r upward, wrapping modulo num_caches_p.
    - Winner is latched into owner_r. ptr_r <= (winner+1) mod num_caches_p, with wrap at num_caches_p-1 -> 0.
  - GRANT (exactly 1 cycle):
    - grant_o = onehot(owner_r); tx_begin_o = 1.
    - -> BUSY. If tx_done_i is already 1 in this cycle, -> GAP directly.
  - BUSY:
    - grant_o is held and tx_begin_o = 0.
    - Stays in BUSY until tx_done_i = 1, then -> GAP.
  - GAP (exactly 1 cycle): grant_o = 0; busy_o = 1; -> IDLE.
    - req_i is ignored in GAP.
    - Arbitration resumes in IDLE on the next cycle, so the minimum grant-to-grant spacing is 3 cycles.
- Latency:
  - IDLE with req_i seen at edge N gives grant_o and tx_begin_o valid in cycle N+1 (registered).
  - Back-to-back spacing: tx_done in cycle T -> GAP at T+1 -> IDLE at T+2 -> GRANT at T+3.
- Signal rules:
  - grant_o, grant_id_o, tx_begin_o and busy_o are registered outputs; there is no combinational path from req_i.
  - tx_done_i is ignored in IDLE and GAP.
  - If the owner deasserts req_i mid-transaction, the grant is still held until tx_done_i.
- Simultaneous requests are resolved strictly by the rotating pointer. No requester waits more than num_caches_p-1 transactions.
- num_caches_p = 1: ptr_r stays 0 and grant_id_o = 0. Sequencing is otherwise identical.
- Reset mid-transaction drops the grant immediately on the next edge and returns all state to reset values.
- Invariant: $onehot0(grant_o) always holds, and grant_o != 0 exactly when the state is GRANT or BUSY.

Optional Feature:
SNOOP_ARB_WATCHDOG_EN
- Defined:
  - A counter of width $clog2(timeout_p+1) clears on entry to GRANT and increments each cycle in BUSY.
  - When the count reaches timeout_p in BUSY without tx_done_i, error_o sets (sticky until reset) and the state forces -> GAP, releasing the grant.
  - ptr_r is unaffected.
- Undefined: no counter is built, error_o is tied 0, and BUSY waits indefinitely.

Test Plan:
1. Post-reset, req_i=2'b01 at cycle 0 -> grant_o=01, grant_id_o=0, tx_begin_o=1 at cycle 1. tx_done_i at cycle 5 -> grant_o=00 at cycle 6, busy_o=0 at cycle 7.
2. req_i=2'b11 held continuously, tx_done_i 2 cycles after each tx_begin -> grants alternate 0,1,0,1. tx_begin spacing is 5 cycles; no grant overlap.
3. num_caches_p=4, ptr_r=3, req_i=4'b0101 -> cache 0 granted (wrap), then ptr_r=1. Next arbitration with req_i=4'b0101 grants cache 2.
4. tx_done_i=1 during the GRANT cycle -> GAP next cycle, one-cycle grant, tx_begin_o still pulsed once.
5. reset_i asserted in BUSY with owner=1 -> next cycle grant_o=0, busy_o=0, ptr_r=0. Then req_i=2'b11 grants cache 0.
6. With SNOOP_ARB_WATCHDOG_EN and timeout_p=16, grant issued and tx_done_i never asserted -> error_o=1 and grant_o=0 after 16 BUSY cycles. error_o stays 1 until reset; the next request is still granted.
